scr1_tb_ahb_master: RTL and testbench
=====================================

Name: scr1_tb_ahb_master

Overview:
Synthesizable AHB-Lite initiator for the SCR1 testbench. It converts a simple command/response stream into single AHB-Lite transfers, with pipelined address and data phases. It drives the same slave-side interface the core's imem/dmem bridges drive, so bench memories and peripherals can be exercised without the core. Typical users are a DMA/preload agent or a directed bus-traffic generator alongside the core.

Parameters:
AHB_WIDTH, 32, width of haddr/hwdata/hrdata and of command/response data.
HPROT_VAL, 4'b0011, constant driven on hprot (data, privileged).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge clk
cmd_write  in  1  1=write, 0=read
cmd_size  in  2  0=byte, 1=half, 2=word (3 reserved, never issued)
cmd_addr  in  AHB_WIDTH  byte address, naturally aligned (caller guarantees)
cmd_wdata  in  AHB_WIDTH  write data, already placed on correct byte lanes
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_rdata  out  AHB_WIDTH  captured hrdata (reads), 0 for writes
rsp_err  out  1  1 = slave returned ERROR
hprot  out  4  HPROT_VAL
hburst  out  3  constant SINGLE (3'b000)
hsize  out  3  {1'b0,cmd_size} of address-phase transfer
htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
hmastlock  out  1  constant 0
haddr  out  AHB_WIDTH  address-phase address
hwrite  out  1  address-phase direction
hwdata  out  AHB_WIDTH  data-phase write data
hready  in  1  slave ready
hrdata  in  AHB_WIDTH  read data
hresp  in  1  0=OKAY, 1=ERROR

Behaviour:
- All outputs are registered except cmd_ready, which is combinational.
- Two stages:
  - A-stage: a_vld plus attributes drive htrans/haddr/hwrite/hsize.
  - D-stage: d_vld, d_write, d_wdata drive hwdata.
- Reset (rst_n=0 at posedge): a_vld=d_vld=0, htrans=IDLE, haddr=0, hwrite=0, hsize=3'b010, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=0 while rst_n=0. In-flight transfers are discarded and produce no response.
- cmd_ready = rst_n & ~cancel & (~a_vld | hready).
- Accept at edge N: htrans=NONSEQ with attributes at cycle N+1.
- A-stage completes on a cycle where a_vld&hready:
  - the transfer moves to D-stage (hwdata valid next cycle);
  - A-stage loads a new command if one is accepted in the same cycle, else goes IDLE.
- While hready=0: haddr/htrans/hwrite/hsize/hwdata are held stable.
- D-stage completes on a cycle where d_vld&hready. Next cycle: rsp_valid=1, rsp_rdata=(d_write?0:hrdata), rsp_err=hresp.
- Latency with zero waits: accept N, address N+1, data N+2, rsp N+3. Throughput is one transfer per cycle.
- ERROR handling (first error cycle: d_vld & hresp & ~hready):
  - if a_vld, set cancel: htrans=IDLE in the second error cycle, A-stage attributes are retained internally;
  - the second error cycle (hready=1, hresp=1) completes the D-stage with rsp_err=1; the idle address phase completes with it;
  - the cycle after, the retained command is re-driven as NONSEQ and cancel clears;
  - no new command is accepted while cancel=1.
- hresp=1 with hready=1 and no preceding error cycle: still reported as rsp_err=1. There is no retry.
- Responses are strictly in command order. At most 2 transfers are outstanding.
- Reset mid-wait-state or mid-error: all state clears on that edge, regardless of hready.

Test Plan:
1. Single write 0x200←0xDEADBEEF, size 2, hready=1:
   - edge N+1: htrans=2'b10, haddr=0x200, hwrite=1, hsize=3'b010;
   - N+2: hwdata=0xDEADBEEF;
   - N+3: rsp_valid=1, rsp_err=0.
2. Four back-to-back reads 0x0/0x4/0x8/0xC, slave returns 0x11/0x22/0x33/0x44, zero waits:
   - NONSEQ on 4 consecutive cycles;
   - rsp_valid on 4 consecutive cycles with rdata 0x11,0x22,0x33,0x44;
   - cmd_ready stays 1.
3. Read 0x100 then write 0x104, hready=0 for 3 cycles in the read data phase:
   - haddr=0x104/NONSEQ/hwrite=1 held 3 cycles, cmd_ready=0;
   - read rsp precedes write rsp.
4. Read 0x1000 with 2-cycle ERROR, read 0x1004 pending:
   - htrans=IDLE in the second error cycle;
   - rsp_err=1 for 0x1000;
   - 0x1004 re-issued NONSEQ the next cycle, completes with rsp_err=0.
5. Byte write 0x203, cmd_wdata=0xAB000000:
   - hsize=3'b000, haddr=0x203, hwdata=0xAB000000 unchanged.
6. rst_n=0 during a wait-stated data phase:
   - next edge: htrans=IDLE, hwdata=0, rsp_valid stays 0;
   - after release, a new command issues normally.

Source files
------------

// File: rtl/scr1_tb_ahb_master.sv
// ---------------------------------------------------------------------------
// scr1_tb_ahb_master
//
// AHB-Lite initiator for the SCR1 testbench. It turns a command/response
// stream into single (non-burst) AHB-Lite transfers. The address and data
// phases are pipelined, so one transfer per cycle is sustained with no
// wait states.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational)
//   cmd_write/size/addr/wdata   command attributes (address naturally aligned,
//                         write data already on the correct byte lanes)
//   rsp_valid/rdata/err   one-cycle response pulse, in command order
//   hprot..hwdata         AHB-Lite master outputs (all registered)
//   hready/hrdata/hresp   AHB-Lite slave inputs
// ---------------------------------------------------------------------------
module scr1_tb_ahb_master #(
  parameter int          AHB_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [1:0]           cmd_size,
  input  logic [AHB_WIDTH-1:0] cmd_addr,
  input  logic [AHB_WIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [AHB_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           hprot,
  output logic [2:0]           hburst,
  output logic [2:0]           hsize,
  output logic [1:0]           htrans,
  output logic                 hmastlock,
  output logic [AHB_WIDTH-1:0] haddr,
  output logic                 hwrite,
  output logic [AHB_WIDTH-1:0] hwdata,
  input  logic                 hready,
  input  logic [AHB_WIDTH-1:0] hrdata,
  input  logic                 hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // A-stage (address phase) state
  logic                 a_vld_q,   a_vld_d;
  logic                 a_write_q, a_write_d;
  logic [1:0]           a_size_q,  a_size_d;
  logic [AHB_WIDTH-1:0] a_addr_q,  a_addr_d;
  logic [AHB_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic [1:0]           htrans_q,  htrans_d;
  // Address phase forced IDLE for one slave response after an ERROR
  logic                 cancel_q,  cancel_d;
  // D-stage (data phase) state
  logic                 d_vld_q,   d_vld_d;
  logic                 d_write_q, d_write_d;
  logic [AHB_WIDTH-1:0] hwdata_q,  hwdata_d;
  // Response
  logic                 rsp_valid_q, rsp_valid_d;
  logic [AHB_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q,   rsp_err_d;

  logic accept;
  logic a_done;
  logic d_done;
  logic err_first;

  always_comb begin
    cmd_ready = rst_n & ~cancel_q & (~a_vld_q | hready);
    accept    = cmd_valid & cmd_ready;
    // A cancelled address phase is IDLE on the bus, so it never hands a
    // transfer to the data phase.
    a_done    = a_vld_q & ~cancel_q & hready;
    d_done    = d_vld_q & hready;
    err_first = d_vld_q & hresp & ~hready;

    a_vld_d     = a_vld_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_addr_d    = a_addr_q;
    a_wdata_d   = a_wdata_q;
    cancel_d    = cancel_q;
    d_vld_d     = d_vld_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;

    // A-stage: load on accept, otherwise drain once the phase completes
    if (accept) begin
      a_vld_d   = 1'b1;
      a_write_d = cmd_write;
      a_size_d  = cmd_size;
      a_addr_d  = cmd_addr;
      a_wdata_d = cmd_wdata;
    end else if (a_done) begin
      a_vld_d   = 1'b0;
    end

    // D-stage: advances only when the slave is ready, so hwdata holds
    // through wait states
    if (hready) begin
      d_vld_d   = a_done;
      d_write_d = a_write_q;
      if (a_done && a_write_q) begin
        hwdata_d = a_wdata_q;
      end
    end

    // The second ERROR cycle (hready=1) also completes the idle address
    // phase; the retained command is re-driven right after it.
    if (cancel_q && hready) begin
      cancel_d = 1'b0;
    end else if (err_first && a_vld_q) begin
      cancel_d = 1'b1;
    end

    htrans_d    = (a_vld_d && !cancel_d) ? HTRANS_NONSEQ : HTRANS_IDLE;

    rsp_valid_d = d_done;
    rsp_rdata_d = (d_done && !d_write_q) ? hrdata : '0;
    rsp_err_d   = d_done & hresp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld_q     <= 1'b0;
      a_write_q   <= 1'b0;
      a_size_q    <= 2'b10;
      a_addr_q    <= '0;
      a_wdata_q   <= '0;
      htrans_q    <= HTRANS_IDLE;
      cancel_q    <= 1'b0;
      d_vld_q     <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_addr_q    <= a_addr_d;
      a_wdata_q   <= a_wdata_d;
      htrans_q    <= htrans_d;
      cancel_q    <= cancel_d;
      d_vld_q     <= d_vld_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign hprot     = HPROT_VAL;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign htrans    = htrans_q;
  assign haddr     = a_addr_q;
  assign hwrite    = a_write_q;
  assign hsize     = {1'b0, a_size_q};
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_scr1_tb_ahb_master.sv
// ---------------------------------------------------------------------------
// Testbench for scr1_tb_ahb_master. The bench acts as the command source and
// the AHB-Lite slave. A transaction-level model (queues of commands waiting
// for their address phase and in their data phase) predicts the bus and
// response outputs, which are compared every cycle. Directed sequences with
// literal expectations come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_scr1_tb_ahb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  hprot;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;

  always #5 clk = ~clk;

  scr1_tb_ahb_master #(.AHB_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_size  (cmd_size),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .hprot     (hprot),
    .hburst    (hburst),
    .hsize     (hsize),
    .htrans    (htrans),
    .hmastlock (hmastlock),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata),
    .hresp     (hresp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit        w;
    bit [1:0]  sz;
    bit [31:0] a;
    bit [31:0] d;
  } cmd_t;

  // Model: commands accepted but not yet through their address phase, and
  // the transfer currently in its data phase.
  cmd_t        aq[$];
  cmd_t        dq[$];
  bit          m_cancel = 1'b0;
  bit          exp_rsp  = 1'b0;
  bit          exp_err  = 1'b0;
  bit [31:0]   exp_rdata = 32'h0;
  bit          err2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] et;
    et = (aq.size() != 0 && !m_cancel) ? 2'b10 : 2'b00;
    chk("htrans", 32'(htrans), 32'(et));
    if (et == 2'b10) begin
      chk("haddr",  haddr,          aq[0].a);
      chk("hwrite", 32'(hwrite),    32'(aq[0].w));
      chk("hsize",  32'(hsize),     32'(aq[0].sz));
    end
    if (dq.size() != 0 && dq[0].w) chk("hwdata", hwdata, dq[0].d);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      chk("rsp_rdata", rsp_rdata,      exp_rdata);
      chk("rsp_err",   32'(rsp_err),   32'(exp_err));
    end
    chk("consts", 32'({hprot, hburst, hmastlock}), 32'({4'b0011, 3'b000, 1'b0}));
  endtask

  // One clock cycle: drive inputs (called at a negedge), check cmd_ready,
  // advance the model over the coming posedge, then check the outputs at
  // the following negedge.
  task automatic cyc(input logic [31:0] rn, input logic [31:0] cv, input logic [31:0] cw,
                     input logic [31:0] cs, input logic [31:0] ca, input logic [31:0] cd,
                     input logic [31:0] hr, input logic [31:0] hp, input logic [31:0] hd);
    bit   er, ad, dd, sc;
    cmd_t c;
    rst_n     = rn[0];
    cmd_valid = cv[0];
    cmd_write = cw[0];
    cmd_size  = cs[1:0];
    cmd_addr  = ca;
    cmd_wdata = cd;
    hready    = hr[0];
    hresp     = hp[0];
    hrdata    = hd;
    #1;
    er = rn[0] && !m_cancel && (aq.size() == 0 || hr[0]);
    chk("cmd_ready", 32'(cmd_ready), 32'(er));
    if (!rn[0]) begin
      aq.delete();
      dq.delete();
      m_cancel  = 1'b0;
      exp_rsp   = 1'b0;
      exp_err   = 1'b0;
      exp_rdata = 32'h0;
      err2      = 1'b0;
    end else begin
      ad = aq.size() != 0 && !m_cancel && hr[0];
      dd = dq.size() != 0 && hr[0];
      sc = dq.size() != 0 && hp[0] && !hr[0] && aq.size() != 0 && !m_cancel;
      exp_rsp   = dd;
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      if (dd) begin
        exp_rdata = dq[0].w ? 32'h0 : hd;
        exp_err   = hp[0];
        void'(dq.pop_front());
      end
      if (ad) dq.push_back(aq.pop_front());
      if (cv[0] && er) begin
        c.w = cw[0]; c.sz = cs[1:0]; c.a = ca; c.d = cd;
        aq.push_back(c);
      end
      m_cancel = (m_cancel && !hr[0]) || sc;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 2, 0, 0, 1, 0, $urandom);
  endtask

  task automatic rand_cyc();
    logic [31:0] rn, cv, cw, cs, ca, cd, hr, hp, hd;
    rn = ($urandom_range(0, 149) != 0) ? 32'd1 : 32'd0;
    cv = ($urandom_range(0, 99) < 70) ? 32'd1 : 32'd0;
    cw = 32'($urandom_range(0, 1));
    cs = 32'($urandom_range(0, 2));
    ca = $urandom;
    if (cs == 1) ca[0] = 1'b0;
    if (cs == 2) ca[1:0] = 2'b00;
    cd = $urandom;
    hd = $urandom;
    if (err2) begin
      hr = 1; hp = 1; err2 = 1'b0;
    end else if (dq.size() != 0 && $urandom_range(0, 99) < 8) begin
      hr = 0; hp = 1; err2 = 1'b1;
    end else begin
      hr = ($urandom_range(0, 99) < 75) ? 32'd1 : 32'd0;
      hp = (dq.size() != 0 && hr[0] && $urandom_range(0, 99) < 3) ? 32'd1 : 32'd0;
    end
    cyc(rn, cv, cw, cs, ca, cd, hr, hp, hd);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 1, 2, 'h40, 'h1, 1, 0, 0);
    // Reset state
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr",  haddr,       32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hsize",  32'(hsize),  32'h2);
    chk("rst_hwdata", hwdata,      32'h0);
    chk("rst_rsp",    32'({rsp_valid, rsp_err}), 32'h0);
    chk("rst_rdata",  rsp_rdata,   32'h0);

    // Single word write
    cyc(1, 1, 1, 2, 'h200, 'hDEADBEEF, 1, 0, 0);
    chk("t1_htrans", 32'(htrans), 32'h2);
    chk("t1_haddr",  haddr,       32'h200);
    chk("t1_hwrite", 32'(hwrite), 32'h1);
    chk("t1_hsize",  32'(hsize),  32'h2);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    chk("t1_hwdata", hwdata, 32'hDEADBEEF);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_err",   32'(rsp_err),   32'h0);
    idle(1);

    // Four back-to-back reads
    cyc(1, 1, 0, 2, 'h0, 0, 1, 0, 0);
    chk("t2_haddr0", haddr, 32'h0);
    cyc(1, 1, 0, 2, 'h4, 0, 1, 0, 0);
    chk("t2_haddr1", haddr, 32'h4);
    cyc(1, 1, 0, 2, 'h8, 0, 1, 0, 'h11);
    chk("t2_rdata0", rsp_rdata, 32'h11);
    cyc(1, 1, 0, 2, 'hC, 0, 1, 0, 'h22);
    chk("t2_rdata1", rsp_rdata, 32'h22);
    chk("t2_haddr3", haddr, 32'hC);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 'h33);
    chk("t2_rdata2", rsp_rdata, 32'h33);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 'h44);
    chk("t2_rdata3", rsp_rdata, 32'h44);
    idle(2);

    // Read then write with three wait states in the read data phase
    cyc(1, 1, 0, 2, 'h100, 0, 1, 0, 0);
    cyc(1, 1, 1, 2, 'h104, 'h55, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 2, 'h108, 0, 0, 0, $urandom);
      chk("t3_hold_haddr",  haddr,       32'h104);
      chk("t3_hold_hwrite", 32'(hwrite), 32'h1);
    end
    cyc(1, 1, 0, 2, 'h108, 0, 1, 0, 'h77);
    chk("t3_rd_rsp", rsp_rdata, 32'h77);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    chk("t3_wr_rsp", 32'({rsp_valid, rsp_rdata == 32'h0}), 32'h3);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 'h88);
    idle(2);

    // Two-cycle ERROR on a read with a second read pending
    cyc(1, 1, 0, 2, 'h1000, 0, 1, 0, 0);
    cyc(1, 1, 0, 2, 'h1004, 0, 1, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 0, 1, 0);
    chk("t4_idle", 32'(htrans), 32'h0);
    cyc(1, 0, 0, 2, 0, 0, 1, 1, 0);
    chk("t4_err",       32'({rsp_valid, rsp_err}), 32'h3);
    chk("t4_reissue",   32'(htrans), 32'h2);
    chk("t4_readdr",    haddr,       32'h1004);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 'h99);
    chk("t4_ok", 32'({rsp_valid, rsp_err}), 32'h2);
    chk("t4_rdata", rsp_rdata, 32'h99);
    idle(2);

    // Byte write
    cyc(1, 1, 1, 0, 'h203, 'hAB000000, 1, 0, 0);
    chk("t5_hsize", 32'(hsize), 32'h0);
    chk("t5_haddr", haddr,      32'h203);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    chk("t5_hwdata", hwdata, 32'hAB000000);
    idle(2);

    // Reset during a wait-stated data phase
    cyc(1, 1, 1, 2, 'h300, 'h12345678, 1, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 2, 0, 0, 0, 0, 0);
    chk("t6_htrans", 32'(htrans),    32'h0);
    chk("t6_hwdata", hwdata,         32'h0);
    chk("t6_rsp",    32'(rsp_valid), 32'h0);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    chk("t6_rsp2",   32'(rsp_valid), 32'h0);
    cyc(1, 1, 0, 2, 'h40, 0, 1, 0, 0);
    chk("t6_new_htrans", 32'(htrans), 32'h2);
    chk("t6_new_haddr",  haddr,       32'h40);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 2, 0, 0, 1, 0, 'h5A5A);
    chk("t6_new_rsp", rsp_rdata, 32'h5A5A);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) rand_cyc();
    for (int n = 0; n < 10; n++) begin
      if (err2) begin
        err2 = 1'b0;
        cyc(1, 0, 0, 2, 0, 0, 1, 1, $urandom);
      end else begin
        cyc(1, 0, 0, 2, 0, 0, 1, 0, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
